exu_result_collector: RTL and testbench

//  Parametrised successor to the fixed 3-slot EXU result bus. Each of CHANNELS functional

---
 rtl/exu_result_collector.sv | 211 +++++++++++++++++++++
 tb/tb_exu_result_collector.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_result_collector.sv
// exu_result_collector: per-channel result FIFOs drained round-robin into registered writeback ports.
// Optional build macro EXU_EXCEPTION_PRIORITY_EN: exception-flagged FIFO heads win arbitration first.

package exu_result_collector_pkg;
    typedef logic [31:0] data_word_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rob_tag;
        logic        exception_generated;
    } instr_packet_t;
endpackage

// exu_rc_fifo: single-clock circular FIFO with occupancy count and synchronous flush.
// Latency: a pushed word is visible on rd_dat the cycle after the push edge.
// Backpressure: push ignored while count==DEPTH, even if a pop happens in the same cycle.
module exu_rc_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_dat,
    output logic [WIDTH-1:0]           rd_dat,
    output logic [$clog2(DEPTH):0]     count_nxt,
    output logic                       empty,
    output logic                       full
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count_q < CW'(DEPTH)) && !flush;
    assign do_pop  = pop && (count_q != '0) && !flush;
    assign rd_dat  = mem[rd_ptr];
    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));

    always_comb begin
        count_nxt = count_q + CW'(do_push) - CW'(do_pop);
        if (flush) begin
            count_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_dat;
    end
endmodule

// exu_result_collector: CHANNELS producer FIFOs arbitrated round-robin onto WB_PORTS registered ports.
// Latency: push at cycle t to an idle, unstalled collector appears on data_valid_o at t+2.
// Backpressure: stall holds outputs and pops; full FIFOs drop pushes and set sticky overflow_o.
module exu_result_collector
    import exu_result_collector_pkg::*;
#(
    parameter int unsigned CHANNELS   = 3,
    parameter int unsigned WB_PORTS   = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           flush_i,
    input  logic                           stall_i,
    input  data_word_t    [CHANNELS-1:0]   result_i,
    input  instr_packet_t [CHANNELS-1:0]   ipacket_i,
    input  logic          [CHANNELS-1:0]   data_valid_i,
    output logic          [CHANNELS-1:0]   full_o,
    output logic          [CHANNELS-1:0]   overflow_o,
    output data_word_t    [WB_PORTS-1:0]   result_o,
    output instr_packet_t [WB_PORTS-1:0]   ipacket_o,
    output logic          [WB_PORTS-1:0]   data_valid_o,
    output logic                           idle_o
);
    localparam int unsigned PTR_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned PORT_W = (WB_PORTS > 1) ? $clog2(WB_PORTS) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
`ifdef EXU_EXCEPTION_PRIORITY_EN
    localparam int unsigned NUM_PASSES = 2;
`else
    localparam int unsigned NUM_PASSES = 1;
`endif

    typedef struct packed {
        instr_packet_t pkt;
        data_word_t    dat;
    } entry_t;

    entry_t [CHANNELS-1:0]             head;
    logic   [CHANNELS-1:0]             empty;
    logic   [CHANNELS-1:0]             grant;
    logic   [CHANNELS-1:0]             pop;
    logic   [CHANNELS-1:0][CNT_W-1:0]  count_nxt;
    entry_t [WB_PORTS-1:0]             port_dat;
    logic   [WB_PORTS-1:0]             port_vld;
    logic   [PTR_W-1:0]                rr_q;
    logic   [PTR_W-1:0]                rr_nxt;
    logic                              idle_nxt;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        exu_rc_fifo #(
            .WIDTH ($bits(entry_t)),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk_i),
            .rst_n     (rst_n_i),
            .flush     (flush_i),
            .push      (data_valid_i[c]),
            .pop       (pop[c]),
            .wr_dat    ({ipacket_i[c], result_i[c]}),
            .rd_dat    (head[c]),
            .count_nxt (count_nxt[c]),
            .empty     (empty[c]),
            .full      (full_o[c])
        );
    end

    // Pass 0 takes only exception heads when priority is built in; the last pass takes anything left.
    always_comb begin
        int unsigned    k;
        int unsigned    idx;
        logic [PTR_W-1:0] ci;
        logic [PTR_W-1:0] last;
        logic           eligible;
        k        = 0;
        idx      = 0;
        ci       = '0;
        last     = rr_q;
        eligible = 1'b0;
        grant    = '0;
        port_dat = '0;
        port_vld = '0;
        for (int unsigned p = 0; p < NUM_PASSES; p++) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                idx      = (32'(rr_q) + i) % CHANNELS;
                ci       = PTR_W'(idx);
                eligible = (p == NUM_PASSES - 1) || head[ci].pkt.exception_generated;
                if (!empty[ci] && !grant[ci] && (k < WB_PORTS) && eligible) begin
                    grant[ci]              = 1'b1;
                    port_dat[PORT_W'(k)]   = head[ci];
                    port_vld[PORT_W'(k)]   = 1'b1;
                    last                   = ci;
                    k                      = k + 1;
                end
            end
        end
        rr_nxt = (last == PTR_W'(CHANNELS - 1)) ? '0 : last + 1'b1;
    end

    assign pop = grant & {CHANNELS{!stall_i && !flush_i}};

    always_comb begin
        idle_nxt = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
            if (count_nxt[c] != '0) idle_nxt = 1'b0;
        end
        if (!flush_i && (stall_i ? (|data_valid_o) : (|port_vld))) idle_nxt = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rr_q         <= '0;
            data_valid_o <= '0;
            result_o     <= '0;
            ipacket_o    <= '0;
            overflow_o   <= '0;
            idle_o       <= 1'b1;
        end else begin
            overflow_o <= overflow_o | (data_valid_i & full_o & {CHANNELS{!flush_i}});
            idle_o     <= idle_nxt;
            if (flush_i) begin
                data_valid_o <= '0;
                result_o     <= '0;
                ipacket_o    <= '0;
            end else if (!stall_i) begin
                data_valid_o <= port_vld;
                for (int p = 0; p < WB_PORTS; p++) begin
                    result_o[p]  <= port_dat[p].dat;
                    ipacket_o[p] <= port_dat[p].pkt;
                end
                if (|grant) rr_q <= rr_nxt;
            end
        end
    end
endmodule

// File: tb/tb_exu_result_collector.sv
// Bench for exu_result_collector: directed scenarios plus randomized traffic against a queue model.
module tb_exu_result_collector;
    import exu_result_collector_pkg::*;

    localparam int CH    = 3;
    localparam int WB    = 1;
    localparam int DEPTH = 4;

    typedef struct packed {
        instr_packet_t p;
        data_word_t    r;
    } ment_t;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     flush;
    logic                     stall;
    data_word_t    [CH-1:0]   res_in;
    instr_packet_t [CH-1:0]   pkt_in;
    logic          [CH-1:0]   dv_in;
    logic          [CH-1:0]   full_o;
    logic          [CH-1:0]   overflow_o;
    data_word_t    [WB-1:0]   result_o;
    instr_packet_t [WB-1:0]   ipacket_o;
    logic          [WB-1:0]   data_valid_o;
    logic                     idle_o;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    ment_t                    mq [CH][$];
    int                       m_rr;
    logic          [WB-1:0]   exp_vld;
    data_word_t    [WB-1:0]   exp_res;
    instr_packet_t [WB-1:0]   exp_pkt;
    logic          [CH-1:0]   m_ovf;
    logic          [CH-1:0]   m_full;
    logic                     m_idle;

    exu_result_collector #(
        .CHANNELS   (CH),
        .WB_PORTS   (WB),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .flush_i      (flush),
        .stall_i      (stall),
        .result_i     (res_in),
        .ipacket_i    (pkt_in),
        .data_valid_i (dv_in),
        .full_o       (full_o),
        .overflow_o   (overflow_o),
        .result_o     (result_o),
        .ipacket_o    (ipacket_o),
        .data_valid_o (data_valid_o),
        .idle_o       (idle_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush  = 1'b0;
        stall  = 1'b0;
        dv_in  = '0;
        res_in = '0;
        pkt_in = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) mq[c].delete();
        m_rr    = 0;
        exp_vld = '0;
        exp_res = '0;
        exp_pkt = '0;
        m_ovf   = '0;
        m_full  = '0;
        m_idle  = 1'b1;
    endtask

    // One clock edge of the collector, expressed as queue operations on the current inputs.
    task automatic model_step();
        int pre[CH];
        int order[$];
        int taken[$];
        for (int c = 0; c < CH; c++) pre[c] = mq[c].size();
        if (flush) begin
            for (int c = 0; c < CH; c++) mq[c].delete();
            exp_vld = '0;
            exp_res = '0;
            exp_pkt = '0;
        end else begin
            if (!stall) begin
                for (int i = 0; i < CH; i++) begin
                    if (mq[(m_rr + i) % CH].size() > 0) order.push_back((m_rr + i) % CH);
                end
`ifdef EXU_EXCEPTION_PRIORITY_EN
                for (int j = 0; j < order.size(); j++)
                    if (mq[order[j]][0].p.exception_generated) taken.push_back(order[j]);
                for (int j = 0; j < order.size(); j++)
                    if (!mq[order[j]][0].p.exception_generated) taken.push_back(order[j]);
`else
                taken = order;
`endif
                for (int k = 0; k < WB; k++) begin
                    if (k < taken.size()) begin
                        ment_t e;
                        e = mq[taken[k]].pop_front();
                        exp_vld[k] = 1'b1;
                        exp_res[k] = e.r;
                        exp_pkt[k] = e.p;
                    end else begin
                        exp_vld[k] = 1'b0;
                        exp_res[k] = '0;
                        exp_pkt[k] = '0;
                    end
                end
                if (taken.size() > 0)
                    m_rr = (taken[(taken.size() < WB) ? taken.size() - 1 : WB - 1] + 1) % CH;
            end
            for (int c = 0; c < CH; c++) begin
                if (dv_in[c]) begin
                    if (pre[c] < DEPTH) mq[c].push_back({pkt_in[c], res_in[c]});
                    else                m_ovf[c] = 1'b1;
                end
            end
        end
        m_idle = (exp_vld == '0);
        for (int c = 0; c < CH; c++) begin
            m_full[c] = (mq[c].size() == DEPTH);
            if (mq[c].size() > 0) m_idle = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        stall = 1'b1;
        dv_in = '1;
        for (int i = 0; i < 5; i++) begin
            res_in = {$urandom(), $urandom(), $urandom()};
            tick();
        end
        n_checks++;
        if (full_o !== 3'b111 || overflow_o !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_prefill: full=%b ovf=%b, need full=111 ovf=111", full_o, overflow_o);
        end
        rst_n = 1'b0;
        stall = 1'b0;
        tick();
        n_checks++;
        if (data_valid_o !== '0 || result_o !== '0 || ipacket_o !== '0 || full_o !== '0 ||
            overflow_o !== '0 || idle_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: dv=%b res=%h pkt=%h full=%b ovf=%b idle=%b, need all 0 idle=1",
                     data_valid_o, result_o, ipacket_o, full_o, overflow_o, idle_o);
        end
        rst_n = 1'b1;
        clear_inputs();
        tick();
        tick();
        n_checks++;
        if (data_valid_o !== '0 || idle_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_discard: dv=%b idle=%b, need dv=0 idle=1", data_valid_o, idle_o);
        end
    endtask

    task automatic test_latency();
        do_reset();
        dv_in[1]  = 1'b1;
        res_in[1] = 32'hDEADBEEF;
        tick();
        clear_inputs();
        n_checks++;
        if (data_valid_o !== 1'b0 || idle_o !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_t1: dv=%b idle=%b, need dv=0 idle=0", data_valid_o, idle_o);
        end
        tick();
        n_checks++;
        if (data_valid_o !== 1'b1 || result_o[0] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL lat_t2: dv=%b res=%h, need dv=1 res=deadbeef", data_valid_o, result_o[0]);
        end
        tick();
        n_checks++;
        if (idle_o !== 1'b1 || data_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_t3: idle=%b dv=%b, need idle=1 dv=0", idle_o, data_valid_o);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        dv_in  = '1;
        res_in = {32'h12, 32'h11, 32'h10};
        tick();
        clear_inputs();
        tick();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (data_valid_o !== 1'b1 || result_o[0] !== 32'(32'h10 + i)) begin
                n_fail++;
                $display("FAIL rr_order%0d: dv=%b res=%h, need dv=1 res=%h",
                         i, data_valid_o, result_o[0], 32'h10 + i);
            end
            tick();
        end
        // pointer back at 0: with ch0 and ch2 both pending, ch0 must go first
        dv_in  = 3'b101;
        res_in = {32'h22, 32'h0, 32'h20};
        tick();
        clear_inputs();
        tick();
        n_checks++;
        if (result_o[0] !== 32'h20) begin
            n_fail++;
            $display("FAIL rr_wrap_first: res=%h, need 20", result_o[0]);
        end
        tick();
        n_checks++;
        if (result_o[0] !== 32'h22) begin
            n_fail++;
            $display("FAIL rr_wrap_second: res=%h, need 22", result_o[0]);
        end
    endtask

    task automatic test_stall_full();
        do_reset();
        stall    = 1'b1;
        dv_in[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            res_in[0] = 32'(32'h40 + i);
            tick();
            if (i == 3) begin
                n_checks++;
                if (full_o !== 3'b001 || overflow_o !== 3'b000) begin
                    n_fail++;
                    $display("FAIL full_after4: full=%b ovf=%b, need full=001 ovf=000", full_o, overflow_o);
                end
            end
        end
        dv_in = '0;
        n_checks++;
        if (overflow_o !== 3'b001 || full_o !== 3'b001 || data_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_5th: ovf=%b full=%b dv=%b, need ovf=001 full=001 dv=0",
                     overflow_o, full_o, data_valid_o);
        end
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (data_valid_o !== 1'b1 || result_o[0] !== 32'(32'h40 + i)) begin
                n_fail++;
                $display("FAIL drain%0d: dv=%b res=%h, need dv=1 res=%h",
                         i, data_valid_o, result_o[0], 32'h40 + i);
            end
        end
        tick();
        n_checks++;
        if (data_valid_o !== 1'b0 || overflow_o !== 3'b001) begin
            n_fail++;
            $display("FAIL drain_end: dv=%b ovf=%b, need dv=0 ovf=001", data_valid_o, overflow_o);
        end
    endtask

    // Continues from test_stall_full so overflow_o[0] is already set.
    task automatic test_flush();
        dv_in[1]  = 1'b1;
        res_in[1] = 32'h51;
        tick();
        clear_inputs();
        tick();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dv_in     = {1'b1, (i < 2), 1'b0};
            res_in[1] = 32'(32'h52 + i);
            res_in[2] = 32'(32'h60 + i);
            tick();
        end
        n_checks++;
        if (data_valid_o !== 1'b1 || result_o[0] !== 32'h51 || full_o !== 3'b100) begin
            n_fail++;
            $display("FAIL stall_hold: dv=%b res=%h full=%b, need dv=1 res=51 full=100",
                     data_valid_o, result_o[0], full_o);
        end
        flush  = 1'b1;
        dv_in  = 3'b110;
        res_in = {32'h77, 32'h66, 32'h0};
        tick();
        clear_inputs();
        n_checks++;
        if (data_valid_o !== 1'b0 || result_o !== '0 || overflow_o !== 3'b001 || full_o !== 3'b000) begin
            n_fail++;
            $display("FAIL flush_clear: dv=%b res=%h ovf=%b full=%b, need dv=0 res=0 ovf=001 full=000",
                     data_valid_o, result_o, overflow_o, full_o);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (data_valid_o !== 1'b0 || idle_o !== 1'b1) begin
                n_fail++;
                $display("FAIL flush_quiet%0d: dv=%b idle=%b, need dv=0 idle=1", i, data_valid_o, idle_o);
            end
        end
    endtask

    task automatic test_exception_priority();
        instr_packet_t pk0;
        instr_packet_t pk2;
        data_word_t    first_res;
        data_word_t    second_res;
        pk0 = '{pc: 32'h1000, rob_tag: 5'd1, exception_generated: 1'b0};
        pk2 = '{pc: 32'h2000, rob_tag: 5'd2, exception_generated: 1'b1};
`ifdef EXU_EXCEPTION_PRIORITY_EN
        first_res  = 32'hA2;
        second_res = 32'hA0;
`else
        first_res  = 32'hA0;
        second_res = 32'hA2;
`endif
        do_reset();
        dv_in     = 3'b101;
        res_in[0] = 32'hA0;
        res_in[2] = 32'hA2;
        pkt_in[0] = pk0;
        pkt_in[2] = pk2;
        tick();
        clear_inputs();
        tick();
        n_checks++;
        if (result_o[0] !== first_res ||
            ipacket_o[0] !== ((first_res == 32'hA2) ? pk2 : pk0)) begin
            n_fail++;
            $display("FAIL exc_first: res=%h pkt=%h, need res=%h", result_o[0], ipacket_o[0], first_res);
        end
        tick();
        n_checks++;
        if (result_o[0] !== second_res ||
            ipacket_o[0] !== ((second_res == 32'hA2) ? pk2 : pk0)) begin
            n_fail++;
            $display("FAIL exc_second: res=%h pkt=%h, need res=%h", result_o[0], ipacket_o[0], second_res);
        end
    endtask

    task automatic test_random();
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            int push_pct;
            push_pct = (cyc < 400) ? 55 : 15;
            flush = ($urandom_range(0, 63) == 0);
            stall = ($urandom_range(0, 99) < 25);
            for (int c = 0; c < CH; c++) begin
                dv_in[c]  = ($urandom_range(0, 99) < push_pct);
                res_in[c] = $urandom();
                pkt_in[c] = '{pc: $urandom(), rob_tag: 5'($urandom()),
                              exception_generated: 1'($urandom())};
            end
            model_step();
            tick();
            n_checks++;
            if (data_valid_o !== exp_vld || result_o !== exp_res || ipacket_o !== exp_pkt ||
                full_o !== m_full || overflow_o !== m_ovf || idle_o !== m_idle) begin
                n_fail++;
                $display("FAIL random cyc%0d: dv=%b res=%h pkt=%h full=%b ovf=%b idle=%b, need dv=%b res=%h pkt=%h full=%b ovf=%b idle=%b",
                         cyc, data_valid_o, result_o, ipacket_o, full_o, overflow_o, idle_o,
                         exp_vld, exp_res, exp_pkt, m_full, m_ovf, m_idle);
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_latency();
        test_round_robin();
        test_stall_full();
        test_flush();
        test_exception_priority();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
